// File: rtl/ring_router_mux.sv
// ring_router_mux: merges ring and local worms onto one registered ring output, whole worms only.
// Define RING_ROUTER_MUX_FAIR_ARB_EN for round-robin IDLE ties; default gives the ring fixed priority.
module ring_router_mux (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_ring_data_i,
  input  logic        in_ring_first_i,
  input  logic        in_ring_last_i,
  input  logic        in_ring_valid_i,
  output logic        in_ring_ready_o,
  input  logic [15:0] in_local_data_i,
  input  logic        in_local_first_i,
  input  logic        in_local_last_i,
  input  logic        in_local_valid_i,
  output logic        in_local_ready_o,
  output logic [15:0] out_ring_data_o,
  output logic        out_ring_first_o,
  output logic        out_ring_last_o,
  output logic        out_ring_valid_o,
  input  logic        out_ring_ready_i
);
  logic        locked_q, locked_d, owner_q, owner_d;
  logic [15:0] data_q, data_d;
  logic        first_q, first_d, last_q, last_d, valid_q, valid_d;
  logic        accept, prio_ring, gnt_ring, gnt_local;
  logic        xfer_ring, xfer_local, xfer, sel_last;
`ifdef RING_ROUTER_MUX_FAIR_ARB_EN
  logic        last_local_q, last_local_d;
  assign prio_ring = last_local_q;
  always_comb last_local_d = (xfer & ~locked_q) ? xfer_local : last_local_q;
  always_ff @(posedge clk) last_local_q <= rst ? 1'b1 : last_local_d;
`else
  assign prio_ring = 1'b1;
`endif
  // owner_q: 1 = LOCAL holds the open worm
  always_comb begin
    accept           = ~valid_q | out_ring_ready_i;
    gnt_ring         = locked_q ? ~owner_q : in_ring_valid_i & (~in_local_valid_i | prio_ring);
    gnt_local        = locked_q ? owner_q : in_local_valid_i & ~gnt_ring;
    in_ring_ready_o  = ~rst & accept & gnt_ring;
    in_local_ready_o = ~rst & accept & gnt_local;
    xfer_ring        = in_ring_ready_o & in_ring_valid_i;
    xfer_local       = in_local_ready_o & in_local_valid_i;
    xfer             = xfer_ring | xfer_local;
    sel_last         = xfer_local ? in_local_last_i : in_ring_last_i;
    valid_d          = accept ? xfer : valid_q;
    data_d           = (accept & xfer) ? (xfer_local ? in_local_data_i : in_ring_data_i) : data_q;
    first_d          = (accept & xfer) ? (xfer_local ? in_local_first_i : in_ring_first_i) : first_q;
    last_d           = (accept & xfer) ? sel_last : last_q;
    locked_d         = xfer ? ~sel_last : locked_q;
    owner_d          = xfer ? xfer_local : owner_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
      owner_q  <= 1'b0;
      data_q   <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      first_q  <= first_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
    end
  end
  // outputs forced quiet during the reset cycle itself, discarding any held flit
  assign out_ring_valid_o = valid_q & ~rst;
  assign out_ring_data_o  = rst ? '0 : data_q;
  assign out_ring_first_o = first_q & ~rst;
  assign out_ring_last_o  = last_q & ~rst;
endmodule

// File: tb/tb_ring_router_mux.sv
// tb_ring_router_mux: scoreboard bench for ring_router_mux framing, arbitration, backpressure and reset.
module tb_ring_router_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] r_data, l_data, o_data;
  logic r_first, r_last, r_valid, r_ready;
  logic l_first, l_last, l_valid, l_ready;
  logic o_first, o_last, o_valid, o_ready;
  int checks = 0;
  int fails = 0;
  typedef struct packed {logic [15:0] d; logic f; logic l;} flit_t;
  flit_t sb[$];
  logic  grants[$];
  logic  tb_open = 1'b0;
  logic  tb_owner = 1'b0;
  flit_t e;
  logic  src;
  logic [3:0] tie_exp;

  ring_router_mux dut (
    .clk(clk), .rst(rst),
    .in_ring_data_i(r_data), .in_ring_first_i(r_first), .in_ring_last_i(r_last),
    .in_ring_valid_i(r_valid), .in_ring_ready_o(r_ready),
    .in_local_data_i(l_data), .in_local_first_i(l_first), .in_local_last_i(l_last),
    .in_local_valid_i(l_valid), .in_local_ready_o(l_ready),
    .out_ring_data_o(o_data), .out_ring_first_o(o_first), .out_ring_last_o(o_last),
    .out_ring_valid_o(o_valid), .out_ring_ready_i(o_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit loc, input logic [15:0] d, input logic f, input logic l, input logic v);
    if (loc) begin
      l_data = d; l_first = f; l_last = l; l_valid = v;
    end else begin
      r_data = d; r_first = f; r_last = l; r_valid = v;
    end
  endtask

  task automatic send(input bit loc, input logic [15:0] base, input int n, input int gap_at = -1, input int gap_len = 0);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        drive(loc, 16'h0, 1'b0, 1'b0, 1'b0);
        cyc(gap_len);
      end
      drive(loc, base + 16'(i), i == 0, i == n - 1, 1'b1);
      begin
        int t = 0;
        @(negedge clk);
        while (!(loc ? l_ready : r_ready) && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (t >= 50) check("send_timeout", t, 0);
      end
      cyc(1);
    end
    drive(loc, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // input-side framing model feeds the scoreboard and the grant log
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      tb_open = 1'b0;
    end else begin
      if (o_valid && o_ready) begin
        if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("out_flit", {o_data, o_first, o_last}, {e.d, e.f, e.l});
        end
      end
      check("one_ready", r_ready & l_ready, 0);
      if (tb_open) check("nonowner_ready", tb_owner ? r_ready : l_ready, 0);
      if ((r_valid && r_ready) || (l_valid && l_ready)) begin
        src = l_valid && l_ready;
        if (tb_open) check("owner_xfer", src, tb_owner);
        else grants.push_back(src);
        sb.push_back(src ? flit_t'{l_data, l_first, l_last} : flit_t'{r_data, r_first, r_last});
        tb_open  = !(src ? l_last : r_last);
        tb_owner = src;
      end
    end
  end

  initial begin
    drive(0, 16'h0, 1'b0, 1'b0, 1'b1);
    drive(1, 16'h0, 1'b0, 1'b0, 1'b1);
    o_ready = 1'b1;
    cyc(1);
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_ring_ready", r_ready, 0);
    check("rst_local_ready", l_ready, 0);
    check("rst_data", {o_data, o_first, o_last}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 16'h0, 1'b0, 1'b0, 1'b0);
    drive(1, 16'h0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    // single-flit local worm
    grants.delete();
    send(1, 16'h1234, 1);
    @(negedge clk);
    check("single_valid", o_valid, 1);
    check("single_flit", {o_data, o_first, o_last}, {16'h1234, 1'b1, 1'b1});
    @(posedge clk); #1;
    send(0, 16'hB100, 1);
    check("single_idle_grants", {grants.size(), 1'b0}, {32'd2, 1'b0});
    cyc(2);
    // local worm locks out ring
    grants.delete();
    fork
      send(1, 16'hA001, 3);
      begin cyc(1); send(0, 16'hB001, 2); end
    join
    cyc(3);
    check("lock_cnt", grants.size(), 2);
    if (grants.size() == 2) begin
      check("lock_g0", grants[0], 1);
      check("lock_g1", grants[1], 0);
    end
    // backpressure on a streaming ring worm
    grants.delete();
    fork
      send(0, 16'hC001, 4);
      begin
        cyc(2);
        o_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_valid", o_valid, 1);
          check("bp_hold", o_data, 16'hC002);
          check("bp_ring_ready", r_ready, 0);
          check("bp_local_ready", l_ready, 0);
        end
        @(posedge clk); #1;
        o_ready = 1'b1;
      end
    join
    cyc(4);
    check("bp_cnt", grants.size(), 1);
    // ties: three ring worms against one local worm
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    grants.delete();
    fork
      begin send(0, 16'hD001, 2); send(0, 16'hD011, 2); send(0, 16'hD021, 2); end
      send(1, 16'hE001, 2);
    join
    cyc(3);
`ifdef RING_ROUTER_MUX_FAIR_ARB_EN
    tie_exp = 4'b0010;
`else
    tie_exp = 4'b1000;
`endif
    check("tie_cnt", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("tie_grant", grants[i], tie_exp[i]);
    // reset mid-worm
    grants.delete();
    drive(0, 16'hF001, 1'b1, 1'b0, 1'b1);
    cyc(1);
    drive(0, 16'hF002, 1'b0, 1'b0, 1'b1);
    drive(1, 16'hA101, 1'b1, 1'b1, 1'b1);
    cyc(1);
    drive(0, 16'hF003, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_ready", {r_ready, l_ready}, 0);
    check("mid_rst_data", o_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_valid", o_valid, 0);
    check("post_rst_local_ready", l_ready, 1);
    @(posedge clk); #1;
    drive(1, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_flit", {o_valid, o_data}, {1'b1, 16'hA101});
    @(posedge clk); #1;
    cyc(2);
    // bubble inside a ring worm with local waiting
    grants.delete();
    fork
      send(0, 16'hC101, 4, 2, 3);
      begin cyc(1); send(1, 16'hA201, 1); end
    join
    cyc(3);
    check("bubble_cnt", grants.size(), 2);
    if (grants.size() == 2) begin
      check("bubble_g0", grants[0], 0);
      check("bubble_g1", grants[1], 1);
    end
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ring_router_mux.md
RING_ROUTER_MUX -- requirements
Module: ring_router_mux

Interface
REQ-001 SHALL have port clk, input, 1 bit, clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-003 SHALL have port in_ring, dii_channel slave (data 16b, first, last, valid in; ready out), worms arriving from the upstream ring segment.
REQ-004 SHALL have port in_local, dii_channel slave, worms injected by the local module.
REQ-005 SHALL have port out_ring, dii_channel master (data, first, last, valid out; ready in), merged stream to the downstream ring segment.

Function
REQ-006 SHALL merge in_ring and in_local onto out_ring as whole worms (first..last flit inclusive); flits of different worms never interleave.
REQ-007 SHALL register out_ring.data/first/last/valid in a single output stage; transfer on input cycle N appears on out_ring in cycle N+1.
REQ-008 Output stage SHALL accept a flit when stage empty or out_ring.ready=1 in that cycle (full throughput, one flit/cycle sustained).
REQ-009 Output stage SHALL hold data/first/last stable while out_ring.valid=1 and out_ring.ready=0.
REQ-010 SHALL keep states IDLE (no worm open) and LOCKED (worm open, owner = RING or LOCAL).
REQ-011 IDLE: arbitration among inputs with valid=1 each cycle; grant combinational, only granted input sees ready = stage-accept condition, other input ready=0.
REQ-012 IDLE -> LOCKED(owner) on transfer of a flit with last=0; a flit with last=1 transferred in IDLE leaves state IDLE (single-flit worm).
REQ-013 LOCKED: only owner's ready may be 1; non-owner ready=0 regardless of its valid.
REQ-014 LOCKED -> IDLE on transfer of owner flit with last=1; next arbitration occurs in the following cycle.
REQ-015 Owner valid=0 while LOCKED (bubble) SHALL hold LOCKED and not grant the other input.
REQ-016 first flag is forwarded unchanged and not used for framing; framing depends on last only.
REQ-017 Both inputs idle (valid=0): no transfer, output stage drains per out_ring.ready.

Reset
REQ-018 While rst=1: out_ring.valid=0, state IDLE, in_ring.ready=0, in_local.ready=0; out data/first/last SHALL be 0.
REQ-019 rst asserted mid-worm SHALL discard the held output flit and any lock; first cycle after rst=0 is a fresh IDLE arbitration.
REQ-020 Round-robin pointer (when compiled in) SHALL reset to "last grant = LOCAL", so RING wins the first tie.

Configuration
REQ-021 Macro RING_ROUTER_MUX_FAIR_ARB_EN SHALL select arbitration policy.
REQ-022 Without macro: fixed priority, in_ring wins every IDLE tie (ring traffic drains first, no ring deadlock).
REQ-023 With macro: round-robin per worm; tie granted to input not granted the previous worm; pointer updates on transfer of each worm's first flit in IDLE.
REQ-024 Policy only affects IDLE ties; REQ-006..REQ-019 unchanged in both builds.

Verification
REQ-025 Single flit: in_local {data=0x1234, first=1, last=1} valid one cycle, out_ring.ready=1 -> out_ring carries 0x1234 first=1 last=1 next cycle, state stays IDLE.
REQ-026 Lock: in_local 3-flit worm (0xA001..0xA003) starts; in_ring valid from cycle 2 -> in_ring.ready=0 until cycle after 0xA003 transferred; out_ring order A001,A002,A003 then ring flits.
REQ-027 Backpressure: out_ring.ready=0 for 4 cycles while 4-flit ring worm streams -> output flit held stable, both input readys 0, no flit lost/duplicated, order preserved after release.
REQ-028 Tie, macro off: both inputs present 2-flit worms every time IDLE -> ring worms always granted, local starves while ring busy; macro on: grants alternate RING, LOCAL, RING, LOCAL.
REQ-029 Reset mid-worm: rst=1 for 1 cycle after 2nd of 5 ring flits -> out_ring.valid=0 during/after reset, state IDLE; local worm then granted without waiting for ring last.
REQ-030 Bubble: owner valid drops 3 cycles mid-worm, other input valid -> other input ready stays 0; worm resumes and completes contiguously on out_ring.
